column_slice_sequencer: RTL
===========================

// Module: column_slice_sequencer
// PURPOSE
//  Initiator side of the slice-height handshake. Per frame, walks every screen column.
//  For each column it pulses begin_calc with column_count held stable, waits for end_calc,
//  then latches slice_size and draws one full vertical column to the VGA adapter:
//  ceiling colour above the slice, wall colour inside it, floor colour below it.
//  It sits between the frame controller (start_frame) and the slice-height calculator plus VGA adapter.
// PARAMETERS
//  SCREEN_W      160     columns per frame; column_count runs 0..SCREEN_W-1
//  SCREEN_H      120     rows per column; y runs 0..SCREEN_H-1
//  CEIL_COLOUR   3'b001  ceiling pixel colour
//  WALL_COLOUR   3'b100  wall pixel colour
//  FLOOR_COLOUR  3'b010  floor pixel colour
//  TIMEOUT_CYC   1024    maximum cycles to wait for end_calc before forcing height 0
// PORTS
//  clock         in   1  system clock; all state changes on the rising edge
//  reset         in   1  synchronous, active-high reset
//  start_frame   in   1  starts a frame when IDLE; ignored otherwise
//  begin_calc    out  1  one-cycle request pulse to the slice-height calculator
//  column_count  out  8  current column; stable from the REQ state until NEXT
//  end_calc      in   1  calculator done strobe
//  slice_size    in   7  calculator result; valid one cycle after end_calc is sampled high
//  x             out  8  pixel x (== column_count while drawing)
//  y             out  7  pixel y
//  colour        out  3  pixel colour
//  plot          out  1  pixel write enable; one pixel per cycle
//  busy          out  1  high in every state except IDLE
//  frame_done    out  1  one-cycle pulse after the last column is drawn
// BEHAVIOUR
//  Reset: state=IDLE; column_count=0, x=0, y=0, colour=0; begin_calc, plot, busy and frame_done all 0.
//  Reset is honoured mid-operation: everything is back at reset values on the next cycle.
//  An in-flight calc result arriving after reset is ignored.
//  States:
//   IDLE    start_frame -> REQ; column_count<=0
//   REQ     begin_calc=1 for exactly 1 cycle; clear timeout counter -> WAIT
//   WAIT    end_calc -> SETTLE
//           counter == TIMEOUT_CYC-1 -> SETTLE with timeout flag (height forced to 0)
//   SETTLE  h <= flag ? 0 : min(slice_size, SCREEN_H)
//           top <= (SCREEN_H - h) >> 1 (unsigned; floor); bot <= top + h; y<=0 -> DRAW
//   DRAW    plot=1 every cycle; x=column_count
//           colour = (y<top) ? CEIL : (y<bot) ? WALL : FLOOR
//           y increments; at y==SCREEN_H-1 -> NEXT
//   NEXT    plot=0; last column (column_count==SCREEN_W-1) -> DONE;
//           otherwise column_count++ -> REQ
//   DONE    frame_done=1 for one cycle -> IDLE
//  h==0: whole column is ceiling for rows < SCREEN_H/2, floor for the rest. No wall pixels.
//  h>=SCREEN_H: whole column is wall (clamped).
//  end_calc outside WAIT is ignored. start_frame while busy is ignored (no queueing).
//  end_calc and timeout in the same cycle: end_calc wins (result used).
//  Per-column latency: 1 (REQ) + Nwait + 1 (SETTLE) + SCREEN_H (DRAW) + 1 (NEXT).
//  Arithmetic: all unsigned; top and bot are 7 bits.
//  x, y and colour change only in DRAW and hold their last value otherwise.
// CONFIGURATION
//  SLICE_SHADE_EN defined:
//   wall pixels of odd columns (column_count[0]==1) use WALL_COLOUR>>1 (dim face shading).
//   Ceiling and floor pixels are unaffected.
//  SLICE_SHADE_EN undefined:
//   all wall pixels use WALL_COLOUR. No extra logic.
// TESTING
//  1 Model returns slice_size=40 for every column, 3 cycles after begin_calc; start_frame pulse:
//    col 0 gives rows 0-39 CEIL, rows 40-79 WALL, rows 80-119 FLOOR.
//    Each column takes 3+3+120 cycles; frame_done pulses once after column 159.
//  2 slice_size=127 -> clamped to 120: every plotted pixel is WALL_COLOUR.
//    slice_size=0 -> rows 0-59 CEIL, rows 60-119 FLOOR.
//  3 Model never asserts end_calc -> after 1024 WAIT cycles the column draws as h=0;
//    sequencer proceeds to the next column with exactly one begin_calc per column.
//  4 Assert reset mid-DRAW at column 37, y=50:
//    next cycle plot=0, busy=0, column_count=0; a late end_calc is ignored;
//    a new start_frame begins again at column 0.
//  5 start_frame held high for the whole frame -> exactly one frame is drawn;
//    a new frame starts in the cycle after DONE returns to IDLE.
//  6 With SLICE_SHADE_EN, slice_size=40 -> wall rows use 3'b100 on column 0
//    and 3'b010 on column 1.

Source files
------------

// File: rtl/column_slice_sequencer.sv
// column_slice_sequencer
//   Initiator side of the slice-height handshake. For every screen column of a
//   frame it requests a slice height from the calculator, waits for the result
//   (or gives up after TIMEOUT_CYC cycles and uses height 0), then plots one
//   full vertical column: ceiling above the slice, wall inside, floor below.
//
//   Optional build macro: SLICE_SHADE_EN
//     When defined, wall pixels in odd columns use WALL_COLOUR>>1 so that
//     alternate column faces read as shaded. Ceiling and floor are unaffected.
module column_slice_sequencer #(
  parameter int          SCREEN_W     = 160,
  parameter int          SCREEN_H     = 120,
  parameter logic [2:0]  CEIL_COLOUR  = 3'b001,
  parameter logic [2:0]  WALL_COLOUR  = 3'b100,
  parameter logic [2:0]  FLOOR_COLOUR = 3'b010,
  parameter int          TIMEOUT_CYC  = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_frame,
  output logic       begin_calc,
  output logic [7:0] column_count,
  input  logic       end_calc,
  input  logic [6:0] slice_size,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       frame_done
);

  localparam int              TO_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]      COL_LAST  = 8'(SCREEN_W - 1);
  localparam logic [6:0]      ROW_LAST  = 7'(SCREEN_H - 1);
  localparam logic [6:0]      SCREEN_H7 = 7'(SCREEN_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_SETTLE,
    S_DRAW,
    S_NEXT,
    S_DONE
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [7:0]      col_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            to_flag_q;
  logic [6:0]      y_q;
  logic [7:0]      x_q;
  logic [2:0]      colour_q;

  logic [6:0]      h_p0;
  logic [6:0]      top_p0;
  logic [6:0]      bot_p0;
  logic [6:0]      top_p1;
  logic [6:0]      bot_p1;

  logic [2:0]      wall_colour;
  logic [2:0]      pix_colour;

  // Height clamp: a timed-out request draws as an empty slice, and anything
  // taller than the screen fills the whole column.
  function automatic logic [6:0] sat_height(input logic timed_out,
                                            input logic [6:0] raw);
    if (timed_out) begin
      return 7'd0;
    end
    if (raw > SCREEN_H7) begin
      return SCREEN_H7;
    end
    return raw;
  endfunction

  // Row classification against the latched slice bounds [top, bot).
  function automatic logic [2:0] band_colour(input logic [6:0] row,
                                             input logic [6:0] top,
                                             input logic [6:0] bot,
                                             input logic [2:0] wall);
    if (row < top) begin
      return CEIL_COLOUR;
    end
    if (row < bot) begin
      return wall;
    end
    return FLOOR_COLOUR;
  endfunction

`ifdef SLICE_SHADE_EN
  assign wall_colour = col_q[0] ? (WALL_COLOUR >> 1) : WALL_COLOUR;
`else
  assign wall_colour = WALL_COLOUR;
`endif

  // ---- stage p0: slice bounds from the calculator result (SETTLE) ----
  assign h_p0   = sat_height(to_flag_q, slice_size);
  assign top_p0 = (SCREEN_H7 - h_p0) >> 1;
  assign bot_p0 = top_p0 + h_p0;

  // ---- stage p1: latched bounds drive the per-row colour (DRAW) ----
  assign pix_colour = band_colour(y_q, top_p1, bot_p1, wall_colour);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; end_calc is checked before the timeout so a result
  // arriving on the last wait cycle is still used.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_frame) state_d = S_REQ;
      S_REQ:    state_d = S_WAIT;
      S_WAIT:   if (end_calc || (to_cnt_q == TO_LAST)) state_d = S_SETTLE;
      S_SETTLE: state_d = S_DRAW;
      S_DRAW:   if (y_q == ROW_LAST) state_d = S_NEXT;
      S_NEXT:   state_d = (col_q == COL_LAST) ? S_DONE : S_REQ;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Decoded outputs; x and colour follow the live pixel while drawing and
  // otherwise show the last plotted pixel.
  always_comb begin
    begin_calc = 1'b0;
    plot       = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b1;
    x          = x_q;
    colour     = colour_q;
    case (state_q)
      S_IDLE: busy       = 1'b0;
      S_REQ:  begin_calc = 1'b1;
      S_DRAW: begin
        plot   = 1'b1;
        x      = col_q;
        colour = pix_colour;
      end
      S_DONE: frame_done = 1'b1;
      default: ;
    endcase
  end

  // Control counters: column index, timeout watchdog, row index and the
  // held pixel outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      col_q     <= 8'd0;
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
      y_q       <= 7'd0;
      x_q       <= 8'd0;
      colour_q  <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_frame) col_q <= 8'd0;
        end
        S_REQ: begin
          to_cnt_q  <= '0;
          to_flag_q <= 1'b0;
        end
        S_WAIT: begin
          if (end_calc) begin
            to_flag_q <= 1'b0;
          end else if (to_cnt_q == TO_LAST) begin
            to_flag_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        S_SETTLE: begin
          y_q <= 7'd0;
        end
        S_DRAW: begin
          x_q      <= col_q;
          colour_q <= pix_colour;
          if (y_q != ROW_LAST) y_q <= y_q + 7'd1;
        end
        S_NEXT: begin
          if (col_q != COL_LAST) col_q <= col_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // ---- stage p0 -> p1: slice bounds captured once per column ----
  always_ff @(posedge clock) begin
    if (state_q == S_SETTLE) begin
      top_p1 <= top_p0;
      bot_p1 <= bot_p0;
    end
  end

  assign column_count = col_q;
  assign y            = y_q;

endmodule
